census_transform: RTL
=====================

Name: census_transform

Overview:
- Streaming census transform that produces the left/right census vectors consumed by the similarity/Hamming cost stage.
- Takes a raster-scan grey pixel stream and buffers WC-1 lines so it can form a WC x WC window.
- Compares each neighbour with the window centre and emits the WC*WC-1 result bits as two NIBIT-wide halves, each with a data-valid strobe.
- One instance per camera: its (o_data_l, o_data_h) pair drives the ll/lh or rl/rh inputs of the cost stage.

Parameters:
- WC, 7, window side. Odd, >= 3.
- M, 650, image width in pixels (line length).
- NBPIX, 8, bits per input pixel.
- Derived: NIBIT = (WC*WC)/2, the width of each output half (24 for WC=7).

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_data  input  NBPIX  pixel, unsigned.
- i_dval  input  1  i_data is valid this cycle (one pixel per beat).
- i_sof  input  1  start of frame; sampled only when i_dval=1, and marks that pixel as row 0, col 0.
- o_data_l  output  NIBIT  census bits 0..NIBIT-1.
- o_data_h  output  NIBIT  census bits NIBIT..2*NIBIT-1.
- o_dval  output  1  o_data_l/o_data_h are valid.

Behaviour:
- Reset: o_dval=0, o_data_l=0, o_data_h=0, and the column and row counters are 0.
  - Line-buffer and window contents are not cleared; the row counter masks them.
- Reset has priority over every other input.
- Reset mid-frame: o_dval=0 from the next cycle. A full WC-1 line refill is required before any new output.
- Stall: when i_dval=0, counters, line buffers and window shift registers hold. o_dval=0 and the o_data outputs hold their last value.
- On each accepted beat (i_dval=1):
  - The pixel is written into the line-buffer chain (WC-1 buffers of M entries, one read and one write per beat).
  - The window shifts left by one column. The new right column is the current pixel plus the WC-1 vertically aligned pixels from the line buffers.
- Window coordinates: row r=0 is the oldest/top line and row WC-1 is the current line. Column c=0 is the oldest/leftmost column and c=WC-1 is the current pixel.
  - The centre is (WC/2, WC/2).
- Column counter: counts 0..M-1 and wraps to 0 after M-1.
  - On wrap, the row counter increments and saturates at WC-1.
- i_sof=1 with i_dval=1: the current pixel is taken as col 0, row 0. Column and row counters restart from that pixel regardless of their previous state.
- Window valid condition, evaluated for the accepted pixel: row_cnt == WC-1 AND col >= WC-1.
  - This guarantees the window never mixes two lines, so the first WC-1 columns of each line produce no output.
- Census bits:
  - Neighbours are numbered in row-major order over (r, c) with the centre skipped: idx = r*WC + c, minus 1 when the position comes after the centre.
  - bit[idx] = 1 iff neighbour < centre (unsigned, strict). Equal values give 0.
  - bit[idx] with idx < NIBIT goes to o_data_l[idx]. bit[idx] with idx >= NIBIT goes to o_data_h[idx-NIBIT].
- Latency: o_dval and o_data are registered.
  - They appear exactly 1 cycle after the i_dval beat that completes a valid window.
  - o_dval is a 1-cycle pulse per valid window.
- Per frame, the number of o_dval pulses is (H-WC+1)*(M-WC+1) for H lines.
- i_dval must not be asserted while i_rst=1; any such beat is ignored.

Test Plan:
All scenarios use WC=3, M=8, NBPIX=8, so NIBIT=4.
1. Flat frame: every pixel = 100, 8 lines, i_sof on the first pixel.
   - o_data_l=0 and o_data_h=0 on every pulse.
   - Exactly 6 pulses per line on lines 2..7, 36 in total.
2. Ramp: pixel = row*8 + col.
   - Every pulse gives o_data_l=4'hF and o_data_h=4'h0, because the 4 neighbours before the centre are smaller.
   - The first pulse comes 1 cycle after accepted beat index 18 (row 2, col 2).
3. Single-window contrast: all 50, with the pixel at row 3, col 4 = 200.
   - The pulse for row 4, col 5 (centre at row 3, col 4) gives o_data_l=4'hF, o_data_h=4'hF.
   - Repeat with the centre = 10: gives 0/0, confirming the strict compare.
4. Stall: scenario 2 re-run with i_dval deasserted on a pseudo-random 40% of cycles.
   - Same 36 output values in the same order.
   - o_dval is never high in a cycle that is not 1 after an accepted beat.
   - o_data holds between pulses.
5. Re-sync: 5 pixels of garbage, then i_sof on a new pixel.
   - No pulse until accepted beat index 18 counted from the i_sof pixel.
   - Output is then identical to scenario 2.
6. Reset mid-frame: assert i_rst for 1 cycle at row 4, col 3, then resume with i_sof.
   - o_dval=0 and o_data=0 on the cycle after reset.
   - The next pulse comes only after 2 full lines plus 3 pixels.

Source files
------------

// File: rtl/census_transform_if.sv
// Pixel-in / census-out stream bundle for census_transform.
// The master drives pixels; the slave (the transform) returns census halves.
interface census_transform_if #(
    parameter int NBPIX = 8,
    parameter int NIBIT = 24
);
    logic [NBPIX-1:0] i_data;
    logic             i_dval;
    logic             i_sof;
    logic [NIBIT-1:0] o_data_l;
    logic [NIBIT-1:0] o_data_h;
    logic             o_dval;

    modport master (
        output i_data, i_dval, i_sof,
        input  o_data_l, o_data_h, o_dval
    );

    modport slave (
        input  i_data, i_dval, i_sof,
        output o_data_l, o_data_h, o_dval
    );
endinterface

// File: rtl/census_transform.sv
// Streaming WC x WC census transform over a raster pixel stream, using WC-1 line buffers.
// Each valid window yields WC*WC-1 "neighbour < centre" bits, split into two halves.
module census_transform #(
    parameter int WC    = 7,
    parameter int M     = 650,
    parameter int NBPIX = 8,
    localparam int NIBIT = (WC * WC) / 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    census_transform_if.slave  bus
);
    localparam int NBITS = WC * WC - 1;
    localparam int HALF  = WC / 2;
    localparam int CW    = (M > 1) ? $clog2(M) : 1;
    localparam int RW    = $clog2(WC);
    localparam logic [CW-1:0] COL_LAST  = CW'(M - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(WC - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(WC - 1);

    logic [NBPIX-1:0] r_lb  [WC-1][M];
    logic [NBPIX-1:0] r_win [WC][WC];
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic             r_dval;
    logic [NIBIT-1:0] r_data_l;
    logic [NIBIT-1:0] r_data_h;

    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    logic [NBPIX-1:0] w_newcol [WC];
    logic [NBPIX-1:0] w_next   [WC][WC];
    logic [NBITS-1:0] w_census;
    logic             w_valid;

    // A start-of-frame beat is treated as col 0 / row 0 whatever the counters held.
    always_comb begin
        w_col   = bus.i_sof ? '0 : r_col;
        w_row   = bus.i_sof ? '0 : r_row;
        w_valid = bus.i_dval && (w_row == ROW_LAST) && (w_col >= COL_FIRST);
    end

    // Buffer k returns the pixel from k+1 lines ago, so it lands in row WC-2-k.
    always_comb begin
        w_newcol[WC-1] = bus.i_data;
        for (int k = 0; k < WC - 1; k++) begin
            w_newcol[WC-2-k] = r_lb[k][w_col];
        end
    end

    always_comb begin
        for (int r = 0; r < WC; r++) begin
            for (int c = 0; c < WC - 1; c++) begin
                w_next[r][c] = r_win[r][c+1];
            end
            w_next[r][WC-1] = w_newcol[r];
        end
    end

    // Row-major neighbour index with the centre position squeezed out.
    always_comb begin
        w_census = '0;
        for (int r = 0; r < WC; r++) begin
            for (int c = 0; c < WC; c++) begin
                if (!(r == HALF && c == HALF)) begin
                    w_census[r*WC + c - (((r*WC + c) > (HALF*WC + HALF)) ? 1 : 0)] =
                        (w_next[r][c] < w_next[HALF][HALF]);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_dval   <= 1'b0;
            r_data_l <= '0;
            r_data_h <= '0;
        end else begin
            r_dval <= w_valid;
            if (bus.i_dval) begin
                if (w_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == ROW_LAST) ? w_row : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
            end
            if (w_valid) begin
                r_data_l <= w_census[NIBIT-1:0];
                r_data_h <= w_census[NBITS-1:NIBIT];
            end
        end
    end

    // Pixel storage is never cleared; the row counter keeps stale data out of valid windows.
    always_ff @(posedge i_clk) begin
        if (!i_rst && bus.i_dval) begin
            r_lb[0][w_col] <= bus.i_data;
            for (int k = 1; k < WC - 1; k++) begin
                r_lb[k][w_col] <= r_lb[k-1][w_col];
            end
            for (int r = 0; r < WC; r++) begin
                for (int c = 0; c < WC; c++) begin
                    r_win[r][c] <= w_next[r][c];
                end
            end
        end
    end

    assign bus.o_dval   = r_dval;
    assign bus.o_data_l = r_data_l;
    assign bus.o_data_h = r_data_h;
endmodule
